// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family.
// Holds the read-mode encodings and the occupancy/pointer width helper.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Pointers and the count need one bit more than the address so that full and empty differ.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_rf.sv
// Storage array for the FIFO: depth x data_width, one synchronous write port, one asynchronous read port.
// The contents are intentionally never reset.
module fifo_mem_rf #(
  parameter int data_width = 4,
  parameter int addr_width = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic [addr_width-1:0] rd_addr,
  output logic [data_width-1:0] rd_data
);

  logic [data_width-1:0] r_mem [(1<<addr_width)];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with fill count, programmable almost flags, standard/FWFT read mode,
// synchronous flush and sticky overflow/underflow flags.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int data_width = 4,
  parameter int addr_width = 3,
  parameter int depth      = 1 << addr_width,
  parameter int af_thresh  = depth - 2,
  parameter int ae_thresh  = 1,
  parameter int fwft       = FIFO_STD
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  wr_en,
  input  logic [data_width-1:0] data_in,
  input  logic                  rd_en,
  output logic [data_width-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int cw = cnt_width(addr_width);

  logic [cw-1:0]         r_wr_ptr;
  logic [cw-1:0]         r_rd_ptr;
  logic [data_width-1:0] r_data_out;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [cw-1:0]         w_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [data_width-1:0] w_rd_data;

  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_empty  = (w_count == '0);
  assign w_full   = (w_count == cw'(depth));

  // Acceptance uses pre-edge flags: a full FIFO rejects a write even if a read frees a slot this cycle.
  assign w_wr_acc = wr_en && !w_full  && !flush;
  assign w_rd_acc = rd_en && !w_empty && !flush;

  fifo_mem_rf #(
    .data_width (data_width),
    .addr_width (addr_width)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_wr_acc),
    .wr_addr (r_wr_ptr[addr_width-1:0]),
    .wr_data (data_in),
    .rd_addr (r_rd_ptr[addr_width-1:0]),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + cw'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + cw'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= '0;
    end else if (flush) begin
      r_data_out <= '0;
    end else if (w_rd_acc) begin
      r_data_out <= w_rd_data;
    end
  end

  // A same-cycle error event wins over clr_err; flush clears regardless.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (wr_en && w_full)  || (r_overflow  && !clr_err);
      r_underflow <= (rd_en && w_empty) || (r_underflow && !clr_err);
    end
  end

  // In FWFT mode the head is shown directly; forcing zero while empty keeps reset/flush output defined.
  assign data_out     = (fwft == FIFO_FWFT) ? (w_empty ? '0 : w_rd_data) : r_data_out;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (w_count <= cw'(ae_thresh));
  assign almost_full  = (w_count >= cw'(af_thresh));
  assign count        = w_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: a vector table for the standard-read instance,
// plus hand-written FWFT, flush and asynchronous-reset sequences.
module tb_sync_fifo_prog;
  import fifo_pkg::*;

  localparam int DW = 4;
  localparam int AW = 3;
  localparam int AF = 6;
  localparam int AE = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, flush, clr_err, wr_en, rd_en;
  logic [DW-1:0] data_in;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
  logic          f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [AW:0]   s_count, f_count;

  sync_fifo_prog #(.data_width(DW), .addr_width(AW), .af_thresh(AF), .ae_thresh(AE),
                   .fwft(FIFO_STD)) u_std (
    .clk(clk), .reset_n(reset_n), .flush(flush), .clr_err(clr_err), .wr_en(wr_en),
    .data_in(data_in), .rd_en(rd_en), .data_out(s_dout), .empty(s_empty), .full(s_full),
    .almost_empty(s_ae), .almost_full(s_af), .count(s_count), .overflow(s_ovf),
    .underflow(s_unf));

  sync_fifo_prog #(.data_width(DW), .addr_width(AW), .af_thresh(AF), .ae_thresh(AE),
                   .fwft(FIFO_FWFT)) u_fwft (
    .clk(clk), .reset_n(reset_n), .flush(flush), .clr_err(clr_err), .wr_en(wr_en),
    .data_in(data_in), .rd_en(rd_en), .data_out(f_dout), .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .count(f_count), .overflow(f_ovf),
    .underflow(f_unf));

  typedef struct {
    logic          wr, rd, fl, clr;
    logic [DW-1:0] din;
    int            cnt;
    logic [DW-1:0] dout;
    logic          ovf, unf;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  // Packed view: {count, empty, full, almost_empty, almost_full, data_out, overflow, underflow}
  function automatic logic [13:0] exp_pack(int cnt, logic [DW-1:0] dout, logic ovf, logic unf);
    logic [3:0] c;
    c = 4'(cnt);
    return {c, (cnt == 0), (cnt == 8), (cnt <= AE), (cnt >= AF), dout, ovf, unf};
  endfunction

  function automatic logic [13:0] act_std();
    return {s_count, s_empty, s_full, s_ae, s_af, s_dout, s_ovf, s_unf};
  endfunction

  function automatic logic [13:0] act_fwft();
    return {f_count, f_empty, f_full, f_ae, f_af, f_dout, f_ovf, f_unf};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got cnt=%0d e=%b f=%b ae=%b af=%b dout=%h ovf=%b unf=%b, want cnt=%0d e=%b f=%b ae=%b af=%b dout=%h ovf=%b unf=%b",
               name, act[13:10], act[9], act[8], act[7], act[6], act[5:2], act[1], act[0],
               exp[13:10], exp[9], exp[8], exp[7], exp[6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  function automatic void add(logic wr, logic rd, logic fl, logic clr, logic [DW-1:0] din,
                              int cnt, logic [DW-1:0] dout, logic ovf, logic unf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.fl = fl; v.clr = clr; v.din = din;
    v.cnt = cnt; v.dout = dout; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic wr, input logic rd, input logic fl, input logic clr,
                       input logic [DW-1:0] din);
    wr_en = wr; rd_en = rd; flush = fl; clr_err = clr; data_in = din;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, '0);
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    reset_n = 1'b1;
    drive(0, 0, 0, 0, '0);

    // wr rd fl clr din | cnt dout ovf unf
    for (int k = 1; k <= 8; k++) add(1, 0, 0, 0, 4'(k), k, 4'h0, 0, 0);
    add(1, 0, 0, 0, 4'h9, 8, 4'h0, 1, 0);
    for (int j = 1; j <= 8; j++) add(0, 1, 0, 0, 4'h0, 8 - j, 4'(j), 1, 0);
    add(0, 1, 0, 0, 4'h0, 0, 4'h8, 1, 1);
    add(0, 0, 0, 1, 4'h0, 0, 4'h8, 0, 0);
    for (int j = 1; j <= 6; j++) add(1, 0, 0, 0, 4'(j), j, 4'h8, 0, 0);
    for (int j = 1; j <= 6; j++) add(0, 1, 0, 0, 4'h0, 6 - j, 4'(j), 0, 0);
    for (int j = 1; j <= 5; j++) add(1, 0, 0, 0, 4'(9 + j), j, 4'h6, 0, 0);
    for (int j = 1; j <= 5; j++) add(0, 1, 0, 0, 4'h0, 5 - j, 4'(9 + j), 0, 0);
    for (int k = 1; k <= 8; k++) add(1, 0, 0, 0, 4'(k), k, 4'hE, 0, 0);
    add(1, 1, 0, 0, 4'hF, 7, 4'h1, 1, 0);
    add(0, 0, 0, 1, 4'h0, 7, 4'h1, 0, 0);
    add(1, 0, 0, 0, 4'h5, 8, 4'h1, 0, 0);
    add(1, 0, 0, 1, 4'h6, 8, 4'h1, 1, 0);
    add(0, 0, 0, 1, 4'h0, 8, 4'h1, 0, 0);
    add(1, 1, 1, 0, 4'h7, 0, 4'h0, 0, 0);
    add(1, 1, 0, 0, 4'h3, 1, 4'h0, 0, 1);
    add(0, 0, 1, 0, 4'h0, 0, 4'h0, 0, 0);

    do_reset();
    check("std_reset", act_std(), exp_pack(0, 4'h0, 0, 0));
    step();
    check("std_idle", act_std(), exp_pack(0, 4'h0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].fl, vecs[i].clr, vecs[i].din);
      step();
      check($sformatf("std_vec%0d", i), act_std(),
            exp_pack(vecs[i].cnt, vecs[i].dout, vecs[i].ovf, vecs[i].unf));
    end
    drive(0, 0, 0, 0, '0);

    do_reset();
    check("fwft_reset", act_fwft(), exp_pack(0, 4'h0, 0, 0));
    drive(1, 0, 0, 0, 4'h9); step();
    check("fwft_first_word", act_fwft(), exp_pack(1, 4'h9, 0, 0));
    drive(0, 0, 0, 0, '0); step();
    check("fwft_hold_head", act_fwft(), exp_pack(1, 4'h9, 0, 0));
    drive(1, 0, 0, 0, 4'h4); step();
    check("fwft_head_stays", act_fwft(), exp_pack(2, 4'h9, 0, 0));
    drive(0, 1, 0, 0, '0); step();
    check("fwft_pop", act_fwft(), exp_pack(1, 4'h4, 0, 0));
    drive(1, 0, 0, 0, 4'h2); step();
    drive(1, 0, 0, 0, 4'h7); step();
    check("fwft_fill", act_fwft(), exp_pack(3, 4'h4, 0, 0));
    drive(1, 0, 1, 0, 4'h1); step();
    check("fwft_flush", act_fwft(), exp_pack(0, 4'h0, 0, 0));
    drive(0, 1, 0, 0, '0); step();
    check("fwft_underflow", act_fwft(), exp_pack(0, 4'h0, 0, 1));
    drive(1, 0, 0, 0, 4'h5); step();
    drive(1, 0, 0, 0, 4'h6); step();
    check("fwft_refill", act_fwft(), exp_pack(2, 4'h5, 0, 1));
    drive(0, 1, 0, 1, '0); step();
    check("fwft_pop_clr", act_fwft(), exp_pack(1, 4'h6, 0, 0));

    // Async reset asserted mid-cycle while a read is requested.
    drive(0, 1, 0, 0, '0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_fwft", act_fwft(), exp_pack(0, 4'h0, 0, 0));
    check("async_rst_std", act_std(), exp_pack(0, 4'h0, 0, 0));
    @(posedge clk); #1;
    check("rst_held_fwft", act_fwft(), exp_pack(0, 4'h0, 0, 0));
    check("rst_held_std", act_std(), exp_pack(0, 4'h0, 0, 0));
    reset_n = 1'b1;
    drive(0, 0, 0, 0, '0);
    step();
    check("post_rst_fwft", act_fwft(), exp_pack(0, 4'h0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
